jump_sequencer: RTL
===================

JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 Parameter MAP_TIMEOUT_CYCLES, default 40000, WAIT_MAP timeout in clk cycles (1 ms at 40 MHz); legal range 2..65535.
REQ-002 clk  input  1  40 MHz pixel/system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; assertion forces reset state immediately, deassertion is synchronous to clk.
REQ-004 module_en  input  1  level; high = gameplay active, low = sequencer held idle.
REQ-005 key  input  2  keyboard code: 00 none, 01 left, 10 right, 11 up (ignored here).
REQ-006 vblnk  input  1  vertical blanking level from VGA timing.
REQ-007 character_landed  input  1  one-cycle pulse, jump animation finished.
REQ-008 jump_fail  input  1  level, sampled only together with character_landed.
REQ-009 map_ready  input  1  level from block generator, new layer available.
REQ-010 jump_left / jump_right  output  1 each  one-cycle jump command pulses.
REQ-011 layer_generate  output  1  one-cycle request for next block layer.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 queue_count  output  2  number of queued jump commands, 0..2.
REQ-014 map_timeout  output  1  sticky error flag.

Function
REQ-015 key shall be registered once; a command is detected when the registered key becomes 01 or 10 and differs from its previous registered value (auto-repeat of a held key is not a new command).
REQ-016 Detected commands shall be pushed into a 2-entry FIFO (1 bit each: 0 left, 1 right); an entry is visible in queue_count the cycle after detection.
REQ-017 Push while full shall be dropped silently, unless a pop occurs the same cycle, in which case the push is accepted and queue_count is unchanged.
REQ-018 Simultaneous push and pop on a non-full queue shall leave queue_count unchanged with FIFO order preserved.
REQ-019 FSM states: IDLE, WAIT_VBL, JUMP, WAIT_LAND, GEN, WAIT_MAP, FAIL.
REQ-020 IDLE -> WAIT_VBL when module_en=1 and queue_count>0.
REQ-021 WAIT_VBL -> JUMP on the cycle a registered vblnk rising edge is detected (vblnk already high on entry does not count).
REQ-022 JUMP lasts exactly one cycle: assert jump_left or jump_right per FIFO head, pop it, -> WAIT_LAND.
REQ-023 WAIT_LAND: on character_landed=1, -> FAIL if jump_fail=1, else -> GEN; no timeout.
REQ-024 GEN lasts one cycle with layer_generate=1, clears timeout counter, -> WAIT_MAP.
REQ-025 WAIT_MAP: map_ready=1 -> IDLE; else counter increments, and when it reaches MAP_TIMEOUT_CYCLES-1 set map_timeout and -> IDLE; map_ready and timeout in the same cycle count as ready (no flag).
REQ-026 FAIL: flush FIFO, ignore keys, remain until module_en=0.
REQ-027 module_en=0 in any state: next cycle state=IDLE, FIFO flushed, all pulse outputs 0, key detection suppressed; map_timeout retained.
REQ-028 At most one of jump_left, jump_right, layer_generate is high in any cycle.
REQ-029 map_timeout clears only on reset.

Reset
REQ-030 During rst=0: state IDLE, FIFO empty, queue_count=0, all outputs 0, timeout counter 0, key/vblnk history registers 0.
REQ-031 First key edge after rst deasserts shall be detected normally (key history reset to 00).
REQ-032 Reset asserted mid-jump or mid-WAIT_MAP shall abort with no further pulses emitted.

Verification
REQ-033 module_en=1, key 00->01 held 100 cycles, one vblnk rise -> exactly one jump_left pulse at first vblnk rise, queue_count 1 then 0.
REQ-034 Keys right, left, right in WAIT_LAND -> queue_count saturates at 2, third dropped; after landed (fail=0) and map_ready, next jump is right, then left.
REQ-035 character_landed with jump_fail=1 and 2 queued -> FAIL, queue_count=0, no layer_generate; module_en low one cycle -> IDLE.
REQ-036 layer_generate then map_ready withheld -> map_timeout=1 after exactly MAP_TIMEOUT_CYCLES cycles in WAIT_MAP, state IDLE, flag holds until rst.
REQ-037 rst low during WAIT_VBL with queue_count=2 -> outputs immediately 0, queue_count=0, no jump pulse on next vblnk rise.
REQ-038 Full queue plus new key edge on the JUMP cycle -> push accepted, queue_count stays 2, order preserved.

Source files
------------

// File: rtl/jump_sequencer.sv
`default_nettype none
// ============================================================================
// jump_sequencer: keyboard jump-command queue and vblank-paced game-step FSM
// Rev 1.0
// ============================================================================
module jump_sequencer #(
    parameter int MAP_TIMEOUT_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       module_en,
    input  logic [1:0] key,
    input  logic       vblnk,
    input  logic       character_landed,
    input  logic       jump_fail,
    input  logic       map_ready,
    output logic       jump_left,
    output logic       jump_right,
    output logic       layer_generate,
    output logic       busy,
    output logic [1:0] queue_count,
    output logic       map_timeout
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(MAP_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VBL  = 3'd1,
        ST_JUMP      = 3'd2,
        ST_WAIT_LAND = 3'd3,
        ST_GEN       = 3'd4,
        ST_WAIT_MAP  = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  key_q, key_prev_q;
    logic        vbl_q, vbl_prev_q;
    logic [1:0]  fifo_q, fifo_d;      // bit 0 is the head; 1 = right
    logic [1:0]  count_q, count_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        map_timeout_q, map_timeout_d;

    logic        cmd_push;
    logic        cmd_pop;
    logic        flush;
    logic        vbl_rise;
    logic [1:0]  fifo_shift;
    logic [1:0]  count_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_q         <= 2'b00;
            key_prev_q    <= 2'b00;
            vbl_q         <= 1'b0;
            vbl_prev_q    <= 1'b0;
            fifo_q        <= 2'b00;
            count_q       <= 2'd0;
            tmo_cnt_q     <= 16'd0;
            map_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key;
            key_prev_q    <= key_q;
            vbl_q         <= vblnk;
            vbl_prev_q    <= vbl_q;
            fifo_q        <= fifo_d;
            count_q       <= count_d;
            tmo_cnt_q     <= tmo_cnt_d;
            map_timeout_q <= map_timeout_d;
        end
    end

    // A held key keeps the same registered code, so only a change is a command
    always_comb begin
        cmd_push = module_en && (state_q != ST_FAIL)
                   && ((key_q == 2'b01) || (key_q == 2'b10))
                   && (key_q != key_prev_q);
        cmd_pop  = module_en && (state_q == ST_JUMP) && (count_q != 2'd0);
        flush    = !module_en || (state_q == ST_FAIL);
        vbl_rise = vbl_q && !vbl_prev_q;
    end

    // Pop first, then append; this lets a push into a full queue land when a
    // pop frees the slot in the same cycle.
    always_comb begin
        fifo_shift  = cmd_pop ? {1'b0, fifo_q[1]} : fifo_q;
        count_shift = count_q - {1'b0, cmd_pop};
        fifo_d      = fifo_shift;
        count_d     = count_shift;
        if (flush) begin
            count_d = 2'd0;
        end else if (cmd_push && (count_shift != 2'd2)) begin
            fifo_d[count_shift[0]] = key_q[1];
            count_d                = count_shift + 2'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_cnt_d      = tmo_cnt_q;
        map_timeout_d  = map_timeout_q;
        jump_left      = 1'b0;
        jump_right     = 1'b0;
        layer_generate = 1'b0;
        if (!module_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (count_q != 2'd0) state_d = ST_WAIT_VBL;
                end
                ST_WAIT_VBL: begin
                    if (vbl_rise) state_d = ST_JUMP;
                end
                ST_JUMP: begin
                    jump_left  = (count_q != 2'd0) && !fifo_q[0];
                    jump_right = (count_q != 2'd0) &&  fifo_q[0];
                    state_d    = ST_WAIT_LAND;
                end
                ST_WAIT_LAND: begin
                    if (character_landed) state_d = jump_fail ? ST_FAIL : ST_GEN;
                end
                ST_GEN: begin
                    layer_generate = 1'b1;
                    tmo_cnt_d      = 16'd0;
                    state_d        = ST_WAIT_MAP;
                end
                ST_WAIT_MAP: begin
                    // ready wins over a coincident timeout
                    if (map_ready) begin
                        state_d = ST_IDLE;
                    end else if (tmo_cnt_q == c_TIMEOUT_LAST) begin
                        map_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign queue_count = count_q;
    assign map_timeout = map_timeout_q;

endmodule
`default_nettype wire
